// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;
    localparam int HC_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_penc8.sv
// Rotating priority encoder: first set request bit found searching upward from ptr, wrapping mod 8.
module rr_penc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    logic [ID_W-1:0] idx;

    // Scan from farthest to nearest so the closest set bit to ptr is the last one written.
    always_comb begin
        id  = ptr;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + ID_W'(i);
            if (req[idx]) begin
                id = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_arb8.sv
// 8-requester round-robin arbiter with bounded hold time and registered one-hot grant.
module rr_arb8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid
);

    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_MAX - 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [HC_W-1:0]  hc_q, hc_d;

    logic             others;
    logic             grant_end;
    logic [ID_W-1:0]  sel_ptr;
    logic [ID_W-1:0]  win_id;
    logic             win_any;

    // The encoder must see the post-grant pointer on the ending edge so a back-to-back
    // winner already treats the outgoing requester as lowest priority.
    assign others    = |(req & ~onehot(gnt_id_q));
    assign grant_end = (state_q == GRANT) &&
                       (!en || !req[gnt_id_q] || ((hc_q == HC_LAST) && others));
    assign sel_ptr   = grant_end ? (gnt_id_q + 3'd1) : ptr_q;

    rr_penc8 u_penc (
        .req (req),
        .ptr (sel_ptr),
        .id  (win_id),
        .any (win_any)
    );

    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        hc_d     = hc_q;

        unique case (state_q)
            IDLE: begin
                if (en && win_any) begin
                    state_d  = GRANT;
                    gnt_id_d = win_id;
                    hc_d     = '0;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    ptr_d = sel_ptr;
                    hc_d  = '0;
                    if (en && win_any) begin
                        gnt_id_d = win_id;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hc_q != HC_LAST) begin
                    hc_d = hc_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gnt_valid_d = (state_d == GRANT);
        gnt_d       = gnt_valid_d ? onehot(gnt_id_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
            hc_q        <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
            hc_q        <= hc_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Scoreboard bench for rr_arb8: stimulus queues hand-computed expectations, a monitor checks them.
module tb_rr_arb8;

    typedef struct {
        string      name;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;

    exp_t sb[$];
    int   total;
    int   bad;

    rr_arb8 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name,
                               input logic [7:0] ag, input logic [2:0] aid, input logic av,
                               input logic [7:0] eg, input logic [2:0] eid, input logic ev);
        total++;
        if (ag !== eg || aid !== eid || av !== ev) begin
            bad++;
            $display("[TB] FAIL %s: got gnt=%h id=%0d valid=%b, want gnt=%h id=%0d valid=%b",
                     name, ag, aid, av, eg, eid, ev);
        end
    endtask

    // Drive inputs at the falling edge; the expectation applies right after the next rising edge.
    task automatic applyStimulus(input logic e, input logic [7:0] r,
                                 input logic [2:0] eid, input logic ev, input string name);
        exp_t x;
        @(negedge clk);
        en      = e;
        req     = r;
        x.name  = name;
        x.id    = eid;
        x.valid = ev;
        x.gnt   = ev ? (8'h01 << eid) : 8'h00;
        sb.push_back(x);
    endtask

    task automatic doReset(input string name);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        #1;
        checkOutput(name, gnt, gnt_id, gnt_valid, 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 50;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: %0d expectations still pending, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput(e.name, gnt, gnt_id, gnt_valid, e.gnt, e.id, e.valid);
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        req   = 8'h00;
        #1;
        checkOutput("por_reset", gnt, gnt_id, gnt_valid, 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester grant and release, then pointer-based selection.
        applyStimulus(1'b1, 8'h04, 3'd2, 1'b1, "t1_grant2");
        applyStimulus(1'b1, 8'h04, 3'd2, 1'b1, "t1_hold2");
        applyStimulus(1'b1, 8'h00, 3'd2, 1'b0, "t1_release");
        applyStimulus(1'b1, 8'h12, 3'd4, 1'b1, "t2_ptr3_picks4");
        applyStimulus(1'b1, 8'h00, 3'd4, 1'b0, "t2_release");
        drain("t2_drain");

        // All requesters held: rotate 0..7,0 with four cycles each, no bubble.
        doReset("t3_reset");
        for (int k = 0; k < 36; k++) begin
            applyStimulus(1'b1, 8'hFF, 3'((k / 4) % 8), 1'b1, $sformatf("t3_rot_k%0d", k));
        end
        applyStimulus(1'b1, 8'h00, 3'd0, 1'b0, "t3_release");
        drain("t3_drain");

        // Sole requester never times out; a newcomer then takes over at once.
        doReset("t4_reset");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 8'h20, 3'd5, 1'b1, $sformatf("t4_sole5_k%0d", k));
        end
        applyStimulus(1'b1, 8'h22, 3'd1, 1'b1, "t4_timeout_to1");
        applyStimulus(1'b1, 8'h22, 3'd1, 1'b1, "t4_hold1");
        applyStimulus(1'b1, 8'h00, 3'd1, 1'b0, "t4_release");
        drain("t4_drain");

        // Enable drop revokes the grant and blocks new ones until re-enabled.
        doReset("t5_reset");
        applyStimulus(1'b1, 8'h08, 3'd3, 1'b1, "t5_grant3");
        applyStimulus(1'b1, 8'h08, 3'd3, 1'b1, "t5_hold3");
        applyStimulus(1'b0, 8'h08, 3'd3, 1'b0, "t5_en_drop");
        applyStimulus(1'b0, 8'h01, 3'd3, 1'b0, "t5_en0_nogrant_a");
        applyStimulus(1'b0, 8'h01, 3'd3, 1'b0, "t5_en0_nogrant_b");
        applyStimulus(1'b1, 8'h01, 3'd0, 1'b1, "t5_reenable_0");
        applyStimulus(1'b1, 8'h00, 3'd0, 1'b0, "t5_release");

        // Reset pulsed between edges mid-grant; pointer returns to 0 afterwards.
        applyStimulus(1'b1, 8'h81, 3'd7, 1'b1, "t6_grant7");
        applyStimulus(1'b1, 8'h81, 3'd7, 1'b1, "t6_hold7");
        drain("t6_drain");
        @(posedge clk);
        #3;
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        #1;
        checkOutput("t6_async_drop", gnt, gnt_id, gnt_valid, 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 8'h81, 3'd0, 1'b1, "t6_after_reset_0");
        applyStimulus(1'b1, 8'h00, 3'd0, 1'b0, "t6_release");
        drain("t6_final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
